// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive (and future transmit) path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead registered head, wrap-bit pointers and
// drop-on-full overrun pulse. Shared between the RX and future TX paths.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_next, rd_ptr_next;
    logic [WIDTH-1:0] head_reg;
    logic             overrun_reg;
    logic             full, do_push, do_pop;
    logic [AW-1:0]    wr_idx, rd_next_idx;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    // Pop is only honoured with data present; a pop frees room for a push in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, do_push};
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, do_pop};
    assign wr_idx      = wr_ptr_reg[AW-1:0];
    assign rd_next_idx = rd_ptr_next[AW-1:0];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            head_reg    <= '0;
            overrun_reg <= 1'b0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            overrun_reg <= push && full && !do_pop;
            // Head is refreshed only when it moves or the first byte lands; bypass covers a write to the new head slot.
            if (do_pop || (do_push && empty)) begin
                head_reg <= (do_push && (wr_idx == rd_next_idx)) ? push_data : mem[rd_next_idx];
            end
        end
    end

    assign head_data = head_reg;
    assign overrun   = overrun_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: 2-FF input synchroniser, mid-bit sampling FSM and a
// byte FIFO presented to the consumer through valid/ready.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_reg;
    logic             rx_s;
    rx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             framing_err_reg;
    logic             push, frame_bad, fifo_empty;

    assign rx_s = sync_reg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg        <= 2'b11;
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            framing_err_reg <= 1'b0;
        end else begin
            sync_reg        <= {sync_reg[0], uart_rx};
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            bit_idx_reg     <= bit_idx_next;
            shift_reg       <= shift_next;
            framing_err_reg <= frame_bad;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CNT_W'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        push         = 1'b0;
        frame_bad    = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // A start bit that is high again at its centre was only a glitch.
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop lets the next start edge be caught back-to-back.
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    push       = rx_s;
                    frame_bad  = !rx_s;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rx_ready),
        .head_data (rx_data),
        .empty     (fifo_empty),
        .overrun   (overrun)
    );

    assign rx_valid    = !fifo_empty;
    assign framing_err = framing_err_reg;
    assign busy        = (state_reg != IDLE);

endmodule
